rvsteel_bus_adapter: RTL and testbench
======================================

# rvsteel_bus_adapter

Bridges the RISC-V Steel core's request/response IO bus to the Controller's synchronous word-wide memory bus. The Controller memory path has no byte enables, so sub-word stores become read-modify-write sequences. The block also performs an address range check and a response timeout. It sits between `rvsteel_core` and the `Controller` in the processor-ci top, clocked by the core clock.

## Interface
Parameters:
- `MEMORY_SIZE`, 4096: memory size in bytes; addresses at or above it are out of range.
- `TIMEOUT_CYCLES`, 255: maximum number of cycles to wait for a memory response; must be at least 1.
- `ERROR_DATA`, 32'hDEADBEEF: value returned on `read_data` for a faulted read.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `rw_address` in 32: core byte address.
- `read_request` in 1: one-cycle pulse; `rw_address` is valid in the same cycle.
- `read_data` out 32: registered read result.
- `read_response` out 1: one-cycle pulse.
- `write_data` in 32: core store data, already lane-aligned.
- `write_strobe` in 4: byte enables; bit i selects bits [8i+7:8i].
- `write_request` in 1: one-cycle pulse.
- `write_response` out 1: one-cycle pulse.
- `mem_read` out 1: one-cycle read strobe to the Controller.
- `mem_write` out 1: one-cycle write strobe to the Controller.
- `mem_address` out 32: word-aligned address, `{rw_address[31:2],2'b00}`.
- `mem_write_data` out 32: word to be written.
- `mem_read_data` in 32: data from the Controller, valid when `mem_read_valid` is high.
- `mem_read_valid` in 1: read-completion pulse.
- `mem_write_ack` in 1: write-completion pulse.
- `bus_error` out 1: sticky error flag, cleared only by reset.

## Operation
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR, WR_WAIT, RESP.
- IDLE, `write_request` high:
  - Latch the address, data and strobe.
  - If out of range: go to RESP with the error flag set.
  - If strobe is 4'b0000: go to RESP; no memory access takes place.
  - If strobe is 4'b1111: assert `mem_write` with `mem_write_data` = `write_data`, then go to WR_WAIT.
  - Any other strobe: assert `mem_read`, then go to RMW_RD.
- IDLE, `read_request` high:
  - If out of range: go to RESP; `read_data` = `ERROR_DATA`.
  - Otherwise: assert `mem_read`, then go to RD_WAIT.
- `read_request` and `write_request` high in the same cycle: the write is served and the read is dropped. No `read_response` is given, and `bus_error` is set.
- RD_WAIT: on `mem_read_valid`, capture `mem_read_data` into `read_data`, then go to RESP.
- RMW_RD: on `mem_read_valid`, form the merged word and assert `mem_write`, then go to WR_WAIT.
  - Merged word, per byte: the stored write byte where its strobe bit is 1, otherwise the byte from `mem_read_data`.
- WR_WAIT: on `mem_write_ack`, go to RESP.
- RESP: pulse `read_response` or `write_response`, whichever matches the latched operation, for one cycle, then go to IDLE.
- Timeout:
  - An 8+ bit counter is cleared on entry to each wait state (RD_WAIT, RMW_RD, WR_WAIT).
  - If the counter reaches `TIMEOUT_CYCLES` without a completion pulse: go to RESP and set `bus_error`.
  - For a timed-out read, `read_data` = `ERROR_DATA`.
  - A completion pulse that arrives later, while in IDLE, is ignored.
- Requests that arrive outside IDLE are ignored; the core never issues them.
- Completion pulses that arrive outside the matching wait state are ignored.

## Timing
- Reset values:
  - Every output is 0: `read_data`, `read_response`, `write_response`, `mem_read`, `mem_write`, `mem_address`, `mem_write_data`, `bus_error`.
  - State is IDLE and the counter is 0.
- All outputs are registered. `mem_read` and `mem_write` are high for exactly one cycle.
- Read, request in cycle T and memory latency L (`mem_read_valid` at T+1+L):
  - `mem_read` is high at T+1.
  - `read_response` is high at T+3+L, with `read_data` valid in that same cycle and held until the next read completes.
- Full-word write:
  - `mem_write` is high at T+1.
  - With the ack at T+1+L, `write_response` is high at T+3+L.
- Partial write:
  - `mem_read` is high at T+1 and `mem_read_valid` arrives at T+1+L1.
  - `mem_write` is high at T+2+L1.
  - With the ack arriving L2 cycles later, `write_response` is high at T+4+L1+L2.
- Strobe 0 or out-of-range request: the response is high at T+2.
- Timeout: the response is high at T+3+`TIMEOUT_CYCLES`, counted from the request cycle T.
- Reset mid-transaction:
  - Immediate return to IDLE with outputs cleared.
  - No response is issued for the aborted request.

## Structure
- Shared package holds:
  - state encodings;
  - the default `ERROR_DATA`;
  - a width-derivation function for the timeout counter.
- One natural sub-module: `byte_merge`, combinational. Inputs are the old word, the new word and the strobe; output is the merged word. It is reused by any other core wrapper that lacks byte enables.

## Test plan
- Read 0x100 with L=3 and `mem_read_data`=0x12345678:
  - `mem_read` is high at T+1 with `mem_address`=0x100.
  - `read_response` is high at T+6 with `read_data`=0x12345678.
- Write 0xAABBCCDD to 0x104 with strobe 4'b1111 and ack latency 0:
  - a single `mem_write` with data 0xAABBCCDD;
  - `write_response` at T+3;
  - no `mem_read`.
- Write 0x0000EE00 to 0x108 with strobe 4'b0010, memory holding 0x11223344:
  - `mem_write_data` is 0x1122EE44.
- Read from address `MEMORY_SIZE` (0x1000):
  - no memory strobes;
  - `read_response` at T+2 with 0xDEADBEEF;
  - `bus_error` is 1.
- Read with `mem_read_valid` never asserted and `TIMEOUT_CYCLES`=8:
  - `read_response` at T+11 with 0xDEADBEEF and `bus_error` set;
  - a later stray `mem_read_valid` causes no response.
- Reset asserted during RMW_RD:
  - all outputs are 0 immediately;
  - no `write_response`;
  - the next read completes normally.

Source files
------------

// File: rtl/rvsteel_bus_adapter_pkg.sv
// rvsteel_bus_adapter_pkg: shared state encodings, default error word and counter sizing
package rvsteel_bus_adapter_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RMW_RD  = 3'd2;
  localparam logic [2:0] S_RMW_WR  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;
  localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hDEADBEEF;
  // Timeout counter must hold TIMEOUT_CYCLES and is never narrower than 8 bits
  function automatic int unsigned cnt_width(input int unsigned t);
    return ($clog2(t + 1) > 8) ? $clog2(t + 1) : 8;
  endfunction
endpackage

// File: rtl/rvsteel_bus_adapter_byte_merge.sv
// rvsteel_bus_adapter_byte_merge: per-byte select of new data over old word by strobe
module rvsteel_bus_adapter_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  strb_i,
  output logic [31:0] merged_o
);
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_o[8*i+:8] = strb_i[i] ? new_i[8*i+:8] : old_i[8*i+:8];
  end
endmodule

// File: rtl/rvsteel_bus_adapter.sv
// rvsteel_bus_adapter: core IO bus to word-wide memory bus bridge with RMW, range check and timeout
module rvsteel_bus_adapter
  import rvsteel_bus_adapter_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE    = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_DATA     = ERROR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rw_address,
  input  logic        read_request,
  output logic [31:0] read_data,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_valid,
  input  logic        mem_write_ack,
  output logic        bus_error
);
  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES);
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic rresp_q, rresp_d, wresp_q, wresp_d, mrd_q, mrd_d, mwr_q, mwr_d;
  logic [3:0] strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, addr_q, addr_d, mwdata_q, mwdata_d;
  logic [31:0] merged;
  logic oor, timeout;
  assign oor = rw_address >= MEMORY_SIZE;
  assign timeout = cnt_q == TO_LAST;
  rvsteel_bus_adapter_byte_merge u_byte_merge (
    .old_i   (mem_read_data),
    .new_i   (wdata_q),
    .strb_i  (strb_q),
    .merged_o(merged)
  );
  // Next-state and registered-output decisions for the transaction FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    err_d    = err_q;
    strb_d   = strb_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    mwdata_d = mwdata_q;
    rresp_d  = 1'b0;
    wresp_d  = 1'b0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (write_request) begin
          wr_d    = 1'b1;
          addr_d  = {rw_address[31:2], 2'b00};
          wdata_d = write_data;
          strb_d  = write_strobe;
          cnt_d   = '0;
          err_d   = err_q | read_request | oor;
          if (oor || write_strobe == 4'b0000) state_d = S_RESP;
          else if (write_strobe == 4'b1111) begin
            mwr_d    = 1'b1;
            mwdata_d = write_data;
            state_d  = S_WR_WAIT;
          end else begin
            mrd_d   = 1'b1;
            state_d = S_RMW_RD;
          end
        end else if (read_request) begin
          wr_d   = 1'b0;
          addr_d = {rw_address[31:2], 2'b00};
          cnt_d  = '0;
          err_d  = err_q | oor;
          rdata_d = oor ? ERROR_DATA : rdata_q;
          mrd_d   = !oor;
          state_d = oor ? S_RESP : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (mem_read_valid) begin
          rdata_d = mem_read_data;
          state_d = S_RESP;
        end else if (timeout) begin
          rdata_d = ERROR_DATA;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_RMW_RD: begin
        if (mem_read_valid) begin
          mwr_d    = 1'b1;
          mwdata_d = merged;
          cnt_d    = '0;
          state_d  = S_WR_WAIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_WR_WAIT: begin
        if (mem_write_ack) state_d = S_RESP;
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_RESP: begin
        rresp_d = !wr_q;
        wresp_d = wr_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State and output registers; reset aborts any transaction without a response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      strb_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      mwdata_q <= '0;
      rresp_q  <= 1'b0;
      wresp_q  <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      strb_q   <= strb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      mwdata_q <= mwdata_d;
      rresp_q  <= rresp_d;
      wresp_q  <= wresp_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
    end
  end
  assign read_data      = rdata_q;
  assign read_response  = rresp_q;
  assign write_response = wresp_q;
  assign mem_read       = mrd_q;
  assign mem_write      = mwr_q;
  assign mem_address    = addr_q;
  assign mem_write_data = mwdata_q;
  assign bus_error      = err_q;
endmodule

// File: tb/tb_rvsteel_bus_adapter.sv
// tb_rvsteel_bus_adapter: randomized transactions against a latency-based reference model
module tb_rvsteel_bus_adapter;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] rw_address = '0, write_data = '0, mem_read_data = '0;
  logic [3:0] write_strobe = '0;
  logic read_request = 1'b0, write_request = 1'b0, mem_read_valid = 1'b0, mem_write_ack = 1'b0;
  logic [31:0] read_data, mem_address, mem_write_data;
  logic read_response, write_response, mem_read, mem_write, bus_error;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem [0:1023];
  bit err_exp = 1'b0;
  always #5 clk = ~clk;
  rvsteel_bus_adapter #(.MEMORY_SIZE(4096), .TIMEOUT_CYCLES(TO), .ERROR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .rw_address(rw_address), .read_request(read_request),
    .read_data(read_data), .read_response(read_response), .write_data(write_data),
    .write_strobe(write_strobe), .write_request(write_request), .write_response(write_response),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid), .mem_write_ack(mem_write_ack), .bus_error(bus_error)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (nw & m) | (old & ~m);
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_rdata"}, read_data, 32'h0);
    chk({tag, "_ctl"}, {27'h0, read_response, write_response, mem_read, mem_write, bus_error}, 32'h0);
    chk({tag, "_maddr"}, mem_address, 32'h0);
    chk({tag, "_mwdata"}, mem_write_data, 32'h0);
  endtask
  // One transaction; l1/d1 shape the read completion, l2/d2 the write ack (d = never answer)
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int l1, input int l2, input bit d1, input bit d2,
                        input string tag);
    bit oor;
    int idx, e_rd, e_wr, e_resp, v_at, a_at, rd_n, rd_at, wr_n, wr_at, rr_n, rr_at, wp_n, wp_at;
    logic [31:0] e_wdata, e_rdata, got_wd, got_rd, got_ma;
    oor = addr >= 32'd4096;
    idx = int'(addr[11:2]);
    e_rd = -1; e_wr = -1; e_wdata = '0; e_rdata = '0;
    v_at = -1; a_at = -1; rd_n = 0; rd_at = -1; wr_n = 0; wr_at = -1;
    rr_n = 0; rr_at = -1; wp_n = 0; wp_at = -1; got_wd = '0; got_rd = '0; got_ma = '0;
    if (wr && rd) err_exp = 1'b1;
    if (wr) begin
      if (oor) begin e_resp = 2; err_exp = 1'b1; end
      else if (strb == 4'b0000) e_resp = 2;
      else if (strb == 4'b1111) begin
        e_wr = 1; e_wdata = wd; e_resp = 3 + (d2 ? TO : l2);
        if (d2) err_exp = 1'b1;
      end else begin
        e_rd = 1;
        if (d1) begin e_resp = 3 + TO; err_exp = 1'b1; end
        else begin
          e_wr = 2 + l1; e_wdata = merge(mem[idx], wd, strb); e_resp = 4 + l1 + (d2 ? TO : l2);
          if (d2) err_exp = 1'b1;
        end
      end
    end else begin
      if (oor) begin e_resp = 2; e_rdata = ERR; err_exp = 1'b1; end
      else begin
        e_rd = 1; e_resp = 3 + (d1 ? TO : l1); e_rdata = d1 ? ERR : mem[idx];
        if (d1) err_exp = 1'b1;
      end
    end
    @(negedge clk);
    rw_address = addr; write_data = wd; write_strobe = strb; write_request = wr; read_request = rd;
    for (int k = 1; k <= e_resp + 3; k++) begin
      @(negedge clk);
      write_request = 1'b0; read_request = 1'b0;
      if (mem_read) begin rd_n++; rd_at = k; got_ma = mem_address; if (!d1) v_at = k + l1; end
      if (mem_write) begin wr_n++; wr_at = k; got_wd = mem_write_data; got_ma = mem_address; if (!d2) a_at = k + l2; end
      if (read_response) begin rr_n++; rr_at = k; got_rd = read_data; end
      if (write_response) begin wp_n++; wp_at = k; end
      mem_read_valid = (k == v_at);
      mem_read_data = (k == v_at) ? mem[idx] : $urandom;
      mem_write_ack = (k == a_at);
      if (k == a_at) mem[idx] = got_wd;
    end
    mem_read_valid = 1'b0; mem_write_ack = 1'b0;
    chk({tag, ":mem_read_n"}, rd_n, (e_rd >= 0) ? 1 : 0);
    chk({tag, ":mem_read_at"}, rd_at, e_rd);
    chk({tag, ":mem_write_n"}, wr_n, (e_wr >= 0) ? 1 : 0);
    chk({tag, ":mem_write_at"}, wr_at, e_wr);
    if (e_wr >= 0) chk({tag, ":mem_wdata"}, got_wd, e_wdata);
    if (e_rd >= 0 || e_wr >= 0) chk({tag, ":mem_addr"}, got_ma, {addr[31:2], 2'b00});
    if (wr) begin
      chk({tag, ":wresp_n"}, wp_n, 1);
      chk({tag, ":wresp_at"}, wp_at, e_resp);
      chk({tag, ":rresp_n"}, rr_n, 0);
    end else begin
      chk({tag, ":rresp_n"}, rr_n, 1);
      chk({tag, ":rresp_at"}, rr_at, e_resp);
      chk({tag, ":rdata"}, got_rd, e_rdata);
      chk({tag, ":wresp_n"}, wp_n, 0);
    end
    chk({tag, ":bus_error"}, bus_error, err_exp);
  endtask
  task automatic quiet(input string tag, input int n);
    int ev;
    ev = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      mem_read_valid = 1'b0; mem_write_ack = 1'b0;
      ev += int'(read_response) + int'(write_response) + int'(mem_read) + int'(mem_write);
    end
    chk({tag, ":no_activity"}, ev, 0);
  endtask
  initial begin
    bit wr, rd, d1, d2;
    logic [31:0] a;
    logic [3:0] s;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    @(negedge clk);
    chk_reset("reset");
    reset = 1'b1;
    mem[32'h100 >> 2] = 32'h12345678;
    do_txn(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 3, 0, 1'b0, 1'b0, "read_0x100");
    do_txn(1'b1, 1'b0, 32'h104, 32'hAABBCCDD, 4'hF, 0, 0, 1'b0, 1'b0, "write_full");
    mem[32'h108 >> 2] = 32'h11223344;
    do_txn(1'b1, 1'b0, 32'h108, 32'h0000EE00, 4'b0010, 1, 1, 1'b0, 1'b0, "write_rmw");
    chk("rmw_result", mem[32'h108 >> 2], 32'h1122EE44);
    do_txn(1'b1, 1'b0, 32'h10C, 32'h55555555, 4'h0, 0, 0, 1'b0, 1'b0, "write_strb0");
    do_txn(1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0, "read_oor");
    do_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 0, 0, 1'b1, 1'b0, "read_timeout");
    @(negedge clk);
    mem_read_valid = 1'b1; mem_write_ack = 1'b1; mem_read_data = 32'hCAFEF00D;
    quiet("stray", 6);
    @(negedge clk);
    rw_address = 32'h108; write_data = 32'h0000AA00; write_strobe = 4'b0010; write_request = 1'b1;
    @(negedge clk);
    write_request = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    err_exp = 1'b0;
    quiet("after_reset", 12);
    do_txn(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 2, 0, 1'b0, 1'b0, "read_after_reset");
    do_txn(1'b1, 1'b1, 32'h200, 32'h0BADF00D, 4'hF, 0, 1, 1'b0, 1'b0, "dual_request");
    do_txn(1'b1, 1'b0, 32'h204, 32'h12121212, 4'b1001, 0, 0, 1'b0, 1'b1, "rmw_ack_timeout");
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? ($urandom_range(0, 9) == 0) : 1'b1;
      a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 32'hFFFF) : $urandom_range(0, 4095);
      s = 4'($urandom_range(0, 15));
      d1 = ($urandom_range(0, 9) == 0);
      d2 = ($urandom_range(0, 9) == 0);
      do_txn(wr, rd, a, $urandom, s, $urandom_range(0, 5), $urandom_range(0, 5), d1, d2, "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
